radix4_mult_arbiter: RTL and testbench

Shares one external Radix-4 sequential multiplier (M, Q operands, 2*WIDTH result, active-high multiplier reset) among NREQ requesters. Round-robin arbitration picks a requester and latches its operands. The block then pulses the multiplier reset, waits a fixed iteration count and captures the product. The product is returned on a single valid/ready response channel tagged with the requester id. Sits between client datapaths and the multiplier instance.

---
 rtl/radix4_mult_arbiter.sv | 176 +++++++++++++++++
 tb/tb_radix4_mult_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/radix4_mult_arbiter.sv
// Round-robin front end sharing one external Radix-4 sequential multiplier among NREQ clients.
// Optional zero-operand shortcut is enabled by defining MULT_ZERO_BYPASS_EN.
module radix4_mult_arbiter #(
  parameter int NREQ       = 4,
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 17,
  parameter int RST_CYCLES = 2,
  parameter int IDW        = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_m,
  input  logic [NREQ*WIDTH-1:0]   req_q,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]      rsp_data,
  output logic [WIDTH-1:0]        mult_m,
  output logic [WIDTH-1:0]        mult_q,
  output logic                    mult_rst,
  input  logic [2*WIDTH-1:0]      mult_out,
  output logic                    busy
);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RUN,
    CAP,
    RESP
  } state_t;

  localparam int CNT_MAX = (MUL_CYCLES > RST_CYCLES) ? MUL_CYCLES : RST_CYCLES;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  state_t               r_state;
  logic [IDW-1:0]       r_rr_ptr;
  logic [IDW-1:0]       r_id;
  logic [CNTW-1:0]      r_cnt;
  logic                 r_bypass;
  logic [WIDTH-1:0]     r_mult_m;
  logic [WIDTH-1:0]     r_mult_q;
  logic                 r_mult_rst;
  logic                 r_rsp_valid;
  logic [IDW-1:0]       r_rsp_id;
  logic [2*WIDTH-1:0]   r_rsp_data;
  logic                 r_busy;

  logic [2*NREQ-1:0]    w_req_rot;
  logic                 w_gnt_any;
  logic [IDW:0]         w_gnt_sum;
  logic [IDW-1:0]       w_gnt;
  logic [IDW-1:0]       w_next_ptr;
  logic [WIDTH-1:0]     w_m_arr [NREQ];
  logic [WIDTH-1:0]     w_q_arr [NREQ];
  logic [WIDTH-1:0]     w_m_sel;
  logic [WIDTH-1:0]     w_q_sel;
  logic                 w_bypass;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_m_arr[i] = req_m[i*WIDTH +: WIDTH];
    assign w_q_arr[i] = req_q[i*WIDTH +: WIDTH];
  end

  // Rotating a doubled copy of the request vector puts the pointer position at
  // bit 0, so the first set bit is the round-robin winner.
  assign w_req_rot = {req_valid, req_valid} >> r_rr_ptr;

  // NOTE: every variable written in a combinational block gets a default at the
  // top, otherwise paths that skip an assignment infer a latch.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_sum = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_gnt_any && w_req_rot[k]) begin
        w_gnt_any = 1'b1;
        w_gnt_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      end
    end
  end

  assign w_gnt      = (w_gnt_sum >= (IDW+1)'(NREQ)) ? IDW'(w_gnt_sum - (IDW+1)'(NREQ))
                                                    : w_gnt_sum[IDW-1:0];
  assign w_next_ptr = (w_gnt == IDW'(NREQ-1)) ? '0 : w_gnt + 1'b1;
  assign w_m_sel    = w_m_arr[w_gnt];
  assign w_q_sel    = w_q_arr[w_gnt];

`ifdef MULT_ZERO_BYPASS_EN
  assign w_bypass = (w_m_sel == '0) || (w_q_sel == '0);
`else
  assign w_bypass = 1'b0;
`endif

  // Accept is combinational so a waiting client transfers on the first IDLE clock.
  assign req_ready = (r_state == IDLE && w_gnt_any) ? (NREQ'(1) << w_gnt) : '0;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_cnt       <= '0;
      r_bypass    <= 1'b0;
      r_mult_m    <= '0;
      r_mult_q    <= '0;
      r_mult_rst  <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_any) begin
            r_mult_m <= w_m_sel;
            r_mult_q <= w_q_sel;
            r_id     <= w_gnt;
            r_rr_ptr <= w_next_ptr;
            r_bypass <= w_bypass;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= w_bypass ? CAP : CLR;
          end
        end
        CLR: begin
          if (r_cnt == CNTW'(RST_CYCLES - 1)) begin
            r_cnt      <= '0;
            r_mult_rst <= 1'b0;
            r_state    <= RUN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RUN: begin
          if (r_cnt == CNTW'(MUL_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_state <= CAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        CAP: begin
          // The product is valid on this clock; the multiplier is parked afterwards.
          r_rsp_data  <= r_bypass ? '0 : mult_out;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_mult_rst  <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mult_m    = r_mult_m;
  assign mult_q    = r_mult_q;
  assign mult_rst  = r_mult_rst;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_radix4_mult_arbiter.sv
// Bench for radix4_mult_arbiter: transaction-level model plus a latency-accurate multiplier stand-in.
// Follows MULT_ZERO_BYPASS_EN for the zero-operand latency.
module tb_radix4_mult_arbiter;

  localparam int NREQ     = 4;
  localparam int W        = 32;
  localparam int MUL      = 17;
  localparam int RST      = 2;
  localparam int IDW      = 2;
  localparam int LAT_FULL = RST + MUL + 1;
`ifdef MULT_ZERO_BYPASS_EN
  localparam bit ZB = 1'b1;
`else
  localparam bit ZB = 1'b0;
`endif

  logic               clk;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*W-1:0]  req_m;
  logic [NREQ*W-1:0]  req_q;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [2*W-1:0]     rsp_data;
  logic [W-1:0]       mult_m;
  logic [W-1:0]       mult_q;
  logic               mult_rst;
  logic [2*W-1:0]     mult_out;
  logic               busy;

  int n_cmp = 0;
  int n_err = 0;

  radix4_mult_arbiter #(
    .NREQ(NREQ), .WIDTH(W), .MUL_CYCLES(MUL), .RST_CYCLES(RST), .IDW(IDW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_m(req_m), .req_q(req_q),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data),
    .mult_m(mult_m), .mult_q(mult_q), .mult_rst(mult_rst),
    .mult_out(mult_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    return sa * sb;
  endfunction

  // Multiplier stand-in: product appears only after MUL clocks out of reset.
  int mcnt = 0;
  always @(posedge clk) begin
    if (mult_rst) mcnt <= 0;
    else if (mcnt < 1000) mcnt <= mcnt + 1;
  end
  assign mult_out = (mcnt >= MUL) ? smul(mult_m, mult_q) : 64'hDEAD_BEEF_DEAD_BEEF;

  function automatic int first_from(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one job in flight, k = clocks since accept.
  bit          m_busy = 1'b0;
  bit          m_byp  = 1'b0;
  int          m_ptr  = 0;
  int          m_id   = 0;
  int          m_k    = 0;
  int          m_lat  = LAT_FULL;
  logic [31:0] m_m    = '0;
  logic [31:0] m_q    = '0;
  logic [63:0] m_prod = '0;

  always @(posedge clk or negedge reset) begin
    int g;
    if (!reset) begin
      m_busy = 1'b0;
      m_ptr  = 0;
      m_k    = 0;
    end else if (!m_busy) begin
      g = first_from(req_valid, m_ptr);
      if (g >= 0) begin
        m_busy = 1'b1;
        m_id   = g;
        m_m    = req_m[g*W +: W];
        m_q    = req_q[g*W +: W];
        m_prod = smul(m_m, m_q);
        m_byp  = ZB && (m_m == 0 || m_q == 0);
        m_lat  = m_byp ? 1 : LAT_FULL;
        m_k    = 0;
        m_ptr  = (g + 1) % NREQ;
      end
    end else if (m_k >= m_lat && rsp_ready) begin
      m_busy = 1'b0;
    end else if (m_k < 1000) begin
      m_k++;
    end
  end

  always @(negedge clk) begin
    logic [NREQ-1:0] er;
    int g;
    if (reset) begin
      er = '0;
      if (!m_busy) begin
        g = first_from(req_valid, m_ptr);
        if (g >= 0) er[g] = 1'b1;
      end
      check("req_ready", 64'(req_ready), 64'(er));
      check("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
      check("busy", 64'(busy), 64'(m_busy));
      check("rsp_valid", 64'(rsp_valid), 64'(m_busy && m_k >= m_lat));
      if (m_busy && m_k >= m_lat) begin
        check("rsp_id", 64'(rsp_id), 64'(m_id));
        check("rsp_data", rsp_data, m_prod);
      end
      if (!m_busy || m_byp || m_k < RST || m_k >= LAT_FULL)
        check("mult_rst_hi", 64'(mult_rst), 64'd1);
      else if (m_k < RST + MUL)
        check("mult_rst_lo", 64'(mult_rst), 64'd0);
      if (m_busy && !m_byp && m_k < LAT_FULL) begin
        check("mult_m", 64'(mult_m), 64'(m_m));
        check("mult_q", 64'(mult_q), 64'(m_q));
      end
    end
  end

  task automatic check_reset_vals();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_data", rsp_data, 64'd0);
    check("rst_mult_m", 64'(mult_m), 64'd0);
    check("rst_mult_q", 64'(mult_q), 64'd0);
    check("rst_mult_rst", 64'(mult_rst), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
  endtask

  task automatic set_req(input int id, input logic [31:0] m, input logic [31:0] q);
    req_m[id*W +: W] = m;
    req_q[id*W +: W] = q;
    req_valid[id]    = 1'b1;
  endtask

  // Returns just after the accepting edge.
  task automatic wait_grant(input int id);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[id] && n < 100);
    check("grant", 64'(req_ready), 64'(1) << id);
    @(posedge clk) #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(input int id, input logic [63:0] data, input int lat, input int hold);
    int n;
    n = 0;
    do begin
      @(posedge clk) #1;
      n++;
    end while (!rsp_valid && n < 100);
    check("latency", 64'(n), 64'(lat));
    check("lit_rsp_id", 64'(rsp_id), 64'(id));
    check("lit_rsp_data", rsp_data, data);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk) #1;
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_data", rsp_data, data);
      check("hold_id", 64'(rsp_id), 64'(id));
      check("hold_mult_rst", 64'(mult_rst), 64'd1);
      check("hold_no_grant", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk) #1;
    rsp_ready = 1'b0;
    check("rsp_drop", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_m     = '0;
    req_q     = '0;
    rsp_ready = 1'b0;
    #12;
    check_reset_vals();
    @(posedge clk) #1;
    reset = 1'b1;

    // Single request and signed operands
    set_req(0, 32'd7, 32'd2);
    wait_grant(0);
    wait_rsp(0, 64'd14, LAT_FULL, 0);
    set_req(1, 32'hFFFF_FFFE, 32'hFFFF_FFFB);
    wait_grant(1);
    wait_rsp(1, 64'd10, LAT_FULL, 0);
    set_req(2, 32'hFFFF_FFFB, 32'd2);
    wait_grant(2);
    wait_rsp(2, 64'hFFFF_FFFF_FFFF_FFF6, LAT_FULL, 0);

    // Reset brings the pointer back to requester 0
    reset = 1'b0;
    #1;
    check_reset_vals();
    @(posedge clk) #1;
    reset = 1'b1;

    // All four contending: grants rotate 0,1,2,3
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i + 1), 32'd3);
    for (int i = 0; i < NREQ; i++) begin
      wait_grant(i);
      wait_rsp(i, 64'(3 * (i + 1)), LAT_FULL, 0);
    end

    // Backpressure with another requester waiting
    set_req(2, 32'd5, 32'd6);
    wait_grant(2);
    set_req(0, 32'h10, 32'h10);
    wait_rsp(2, 64'd30, LAT_FULL, 10);
    wait_grant(0);
    wait_rsp(0, 64'd256, LAT_FULL, 0);

    // Reset five clocks into RUN, then the same request again
    set_req(3, 32'hFFFF_FF01, 32'h139);
    wait_grant(3);
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals();
    @(posedge clk) #1;
    reset = 1'b1;
    set_req(3, 32'hFFFF_FF01, 32'h139);
    wait_grant(3);
    wait_rsp(3, 64'hFFFF_FFFF_FFFE_C839, LAT_FULL, 0);

    // Zero operand
    set_req(0, 32'hF000_00F5, 32'd0);
    wait_grant(0);
    wait_rsp(0, 64'd0, ZB ? 1 : LAT_FULL, 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
